// File: rtl/ltc2308_spi_ctrl.sv
// ltc2308_spi_ctrl: conversion controller for the LTC2308 8-channel 12-bit ADC.
// One frame = CONVST pulse, 24-cycle SPI shift (12 SCK periods at clk/2),
// one result cycle. The word read in a frame belongs to the conversion set up
// by the previous frame's config word, so the first frame after reset or abort
// only primes the ADC.
// Build option: define ADC_AUTO_SCAN_EN for free-running scanning of channels
// 0..7. Without it, one frame runs per accepted start on channel ch.
`timescale 1ns/1ps

module ltc2308_spi_ctrl #(
   parameter int unsigned CONV_CYCLES = 66
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pll_locked,
   input  logic        start,
   input  logic [2:0]  ch,
   output logic        busy,
   output logic        data_valid,
   output logic [11:0] data,
   output logic [2:0]  data_ch,
   output logic        adc_convst,
   output logic        adc_sck,
   output logic        adc_sdi,
   input  logic        adc_sdo
);

   localparam logic [7:0] CONV_LAST  = 8'(CONV_CYCLES);
   localparam logic [4:0] SHIFT_LAST = 5'd23;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CONV  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   // LTC2308 config word, sent MSB first: S/D, O/S, S1, S0, UNI, SLP.
   // Single-ended, unipolar, no sleep; the channel bits are scrambled the
   // way the ADC's address table expects.
   function automatic logic [5:0] cfg_word_of(input logic [2:0] c);
      return {1'b1, c[0], c[2], c[1], 1'b1, 1'b0};
   endfunction

   state_t      state;
   state_t      state_next;
   logic [7:0]  conv_cnt;
   logic [4:0]  bit_cnt;
   logic [5:0]  cfg_word;
   logic [2:0]  cfg_ch;
   logic [2:0]  prev_ch;
   logic [11:0] sdo_shift;
   logic        first_frame;
   logic        abort;
   logic        start_go;
   logic [2:0]  start_ch;
   logic        conv_end;
   logic        sck_rise;

   // Losing PLL lock while a frame is in flight drops everything back to IDLE.
   assign abort    = (state != IDLE) && !pll_locked;
   assign conv_end = (state == CONV) && (conv_cnt == CONV_LAST);
   // Even shift cycles drive SCK high (and sample SDO), odd ones drive it low.
   assign sck_rise = (state == SHIFT) && !bit_cnt[0];

`ifdef ADC_AUTO_SCAN_EN
   logic [2:0] scan_ch;
   logic       unused_manual_inputs;

   assign unused_manual_inputs = ^{start, ch};
   assign start_go = pll_locked;
   assign start_ch = scan_ch;

   // Scan channel: advances on every frame start, restarts at 0 after abort.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_ch <= 3'd0;
      end else if (abort) begin
         scan_ch <= 3'd0;
      end else if ((state == IDLE) && start_go) begin
         scan_ch <= scan_ch + 3'd1;
      end
   end
`else
   assign start_go = start && pll_locked;
   assign start_ch = ch;
`endif

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state logic; abort overrides every non-IDLE transition.
   always_comb begin
      state_next = state;
      if (abort) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start_go) begin
                  state_next = CONV;
               end else begin
                  state_next = IDLE;
               end
            end
            CONV: begin
               if (conv_cnt == CONV_LAST) begin
                  state_next = SHIFT;
               end else begin
                  state_next = CONV;
               end
            end
            SHIFT: begin
               if (bit_cnt == SHIFT_LAST) begin
                  state_next = DONE;
               end else begin
                  state_next = SHIFT;
               end
            end
            DONE: begin
               state_next = IDLE;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // CONVST timer and SPI cycle counter; both rearm while idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conv_cnt <= 8'd0;
         bit_cnt  <= 5'd0;
      end else begin
         case (state)
            IDLE: begin
               // CONVST goes high on the accepting edge, which is cycle 1.
               conv_cnt <= 8'd1;
               bit_cnt  <= 5'd0;
            end
            CONV: begin
               conv_cnt <= conv_cnt + 8'd1;
               bit_cnt  <= 5'd0;
            end
            SHIFT: begin
               bit_cnt <= bit_cnt + 5'd1;
            end
            default: begin
               bit_cnt <= 5'd0;
            end
         endcase
      end
   end

   // Config word load/serialisation and SDO capture register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_word  <= 6'd0;
         cfg_ch    <= 3'd0;
         sdo_shift <= 12'd0;
      end else begin
         if ((state == IDLE) && start_go) begin
            cfg_word <= cfg_word_of(start_ch);
            cfg_ch   <= start_ch;
         end else if (!abort && (conv_end || ((state == SHIFT) && bit_cnt[0]))) begin
            // Zeros fill in behind, so SDI idles low after the sixth bit.
            cfg_word <= {cfg_word[4:0], 1'b0};
         end
         if (!abort && sck_rise) begin
            sdo_shift <= {sdo_shift[10:0], adc_sdo};
         end
      end
   end

   // ADC pins, all straight from flops; SDI only moves while SCK is driven low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         adc_convst <= 1'b0;
         adc_sck    <= 1'b0;
         adc_sdi    <= 1'b0;
      end else if (abort) begin
         adc_convst <= 1'b0;
         adc_sck    <= 1'b0;
         adc_sdi    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               adc_convst <= start_go;
               adc_sck    <= 1'b0;
               adc_sdi    <= 1'b0;
            end
            CONV: begin
               if (conv_cnt == CONV_LAST) begin
                  adc_convst <= 1'b0;
                  adc_sdi    <= cfg_word[5];
               end
               adc_sck <= 1'b0;
            end
            SHIFT: begin
               if (!bit_cnt[0]) begin
                  adc_sck <= 1'b1;
               end else begin
                  adc_sck <= 1'b0;
                  adc_sdi <= cfg_word[5];
               end
            end
            default: begin
               adc_convst <= 1'b0;
               adc_sck    <= 1'b0;
               adc_sdi    <= 1'b0;
            end
         endcase
      end
   end

   // Result outputs, channel pipeline and priming flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy        <= 1'b0;
         data_valid  <= 1'b0;
         data        <= 12'd0;
         data_ch     <= 3'd0;
         prev_ch     <= 3'd0;
         first_frame <= 1'b1;
      end else begin
         busy <= (state_next != IDLE);
         if (abort) begin
            data_valid  <= 1'b0;
            first_frame <= 1'b1;
         end else if (state == DONE) begin
            data        <= sdo_shift;
            data_ch     <= prev_ch;
            prev_ch     <= cfg_ch;
            data_valid  <= !first_frame;
            first_frame <= 1'b0;
         end else begin
            data_valid <= 1'b0;
         end
      end
   end

endmodule
